func_hdl_ostream_buf: RTL and testbench

//  Output-side stream buffer directly downstream of func_hdl_top's m_* port.

---
 rtl/func_hdl_ostream_buf.sv | 190 +++++++++++++++++++
 tb/tb_func_hdl_ostream_buf.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/func_hdl_ostream_buf.sv
// func_hdl_ostream_buf: output-side stream buffer between func_hdl_top's master port and the
// write-DMA AXI-stream master. Buffers beats in a FIFO, frames a run of xfer_len beats with
// m_tlast on the final one and pulses done once that beat has handshaked.
//
// Optional feature: define TY_OSTALL_CNT_EN to add the stall_cnt port, a saturating count of
// RUN cycles in which a beat was offered to the DMA but not taken.
module func_hdl_ostream_buf #(
  parameter int unsigned C_DATA_WIDTH = 128,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned LENW         = 32
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    start,
  input  logic [LENW-1:0]         xfer_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  output logic                    s_tready,
  output logic                    m_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tlast,
  input  logic                    m_tready
`ifdef TY_OSTALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic [LENW-1:0]         len_q;
  logic [LENW-1:0]         in_cnt_q;
  logic [LENW-1:0]         out_cnt_q;

  // FIFO storage and pointers; the extra pointer MSB distinguishes full from empty.
  logic [C_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]         wr_ptr_q;
  logic [PtrW-1:0]         rd_ptr_q;
  logic [PtrW-1:0]         fifo_cnt;
  logic [AW-1:0]           rd_idx_nxt;
  logic                    fifo_full;
  logic                    fifo_empty;

  // Output register holds a copy of the FIFO head; the entry is only retired on handshake,
  // so the displayed beat still occupies a FIFO slot.
  logic                    out_valid_q;
  logic [C_DATA_WIDTH-1:0] out_data_q;

  logic                    push;
  logic                    pop;
  logic                    last_beat;
  logic                    start_ok;

  // Status decode from registered state only.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    fifo_cnt   = wr_ptr_q - rd_ptr_q;
    rd_idx_nxt = rd_ptr_q[AW-1:0] + AW'(1);
    s_tready   = (state_q == StRun) && !fifo_full && (in_cnt_q < len_q);
    push       = s_tvalid && s_tready;
    pop        = out_valid_q && m_tready;
    last_beat  = (out_cnt_q == len_q - LENW'(1));
    start_ok   = start && (state_q == StIdle);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign m_tvalid = out_valid_q;
  assign m_tdata  = out_data_q;
  assign m_tlast  = out_valid_q && last_beat;

  // Transfer FSM with registered busy/done and the beat counters.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            len_q     <= xfer_len;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (xfer_len != '0) begin
              state_q <= StRun;
            end else begin
              // Empty transfer: no beats, straight to the done pulse.
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (push) begin
            in_cnt_q <= in_cnt_q + LENW'(1);
          end
          if (pop) begin
            out_cnt_q <= out_cnt_q + LENW'(1);
            if (last_beat) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write pointer advances on every accepted upstream beat.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + PtrW'(1);
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_tdata;
    end
  end

  // Registered FWFT output stage: on handshake prefetch the next entry if one is already
  // stored, otherwise go idle and load the head on a later cycle.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (pop) begin
      rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (fifo_cnt > PtrW'(1)) begin
        out_data_q <= mem_q[rd_idx_nxt];
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (!out_valid_q && !fifo_empty) begin
      out_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
      out_valid_q <= 1'b1;
    end
  end

`ifdef TY_OSTALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating DMA backpressure counter; held after the transfer for software readback.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && out_valid_q && !m_tready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_func_hdl_ostream_buf.sv
// Scoreboard bench for func_hdl_ostream_buf: directed transfers queue their expected beats,
// an independent monitor retires them on every output handshake.
module tb_func_hdl_ostream_buf;

  localparam int unsigned DW = 128;

  logic          aclk     = 1'b0;
  logic          areset_n = 1'b0;
  logic          start    = 1'b0;
  logic [31:0]   xfer_len = '0;
  logic          busy;
  logic          done;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready = 1'b0;
`ifdef TY_OSTALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  func_hdl_ostream_buf #(
    .C_DATA_WIDTH(DW),
    .DEPTH       (16),
    .LENW        (32)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .start    (start),
    .xfer_len (xfer_len),
    .busy     (busy),
    .done     (done),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
`ifdef TY_OSTALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    tests    = 0;
  int    fails    = 0;
  int    accepted = 0;
  int    done_cnt = 0;
  int    d0       = 0;
  bit    seen     = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_run(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = DW'(base + i);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that samples start.
  task automatic do_start(input int len);
    start    = 1'b1;
    xfer_len = 32'(len);
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int base);
    bit got;
    for (int i = 0; i < n; i++) begin
      got      = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = DW'(base + i);
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge aclk);
        if (s_tready) got = 1'b1;
      end
      if (!got) begin
        check("send_timeout", DW'(got), 1);
        s_tvalid = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
      accepted++;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit got;
    got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge aclk);
      if (done) got = 1'b1;
    end
    check("done_timeout", DW'(got), 1);
  endtask

  // Monitor: retires expected beats on handshake and checks AXI hold while stalled.
  initial begin
    beat_t         e;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", DW'(m_tvalid), 1);
          check("hold_data", m_tdata, prev_data);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat_queue", DW'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_tdata, e.data);
            check("beat_last", DW'(m_tlast), DW'(e.last));
          end
        end
        if (!m_tvalid) check("tlast_without_valid", DW'(m_tlast), 0);
        if (done) done_cnt++;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests so far", tests);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge aclk);
    check("rst_busy", DW'(busy), 0);
    check("rst_done", DW'(done), 0);
    check("rst_s_tready", DW'(s_tready), 0);
    check("rst_m_tvalid", DW'(m_tvalid), 0);
    check("rst_m_tlast", DW'(m_tlast), 0);
    check("rst_m_tdata", m_tdata, 0);
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    @(posedge aclk);
    #1;

    // T1: 4 beats, DMA always ready
    expect_run(4, 1);
    m_tready = 1'b1;
    d0       = done_cnt;
    do_start(4);
    fork
      send_beats(4, 1);
      begin
        @(negedge aclk);
        @(negedge aclk);
        check("t1_no_passthrough", DW'(m_tvalid), 0);
        @(negedge aclk);
        check("t1_first_valid", DW'(m_tvalid), 1);
        check("t1_first_data", m_tdata, 1);
        repeat (4) @(negedge aclk);
        check("t1_done", DW'(done), 1);
        check("t1_busy_in_done", DW'(busy), 1);
        @(negedge aclk);
        check("t1_done_pulse", DW'(done), 0);
        check("t1_busy_idle", DW'(busy), 0);
      end
    join
    @(posedge aclk);
    #1;
    check("t1_queue_empty", DW'(exp_q.size()), 0);
    check("t1_done_count", DW'(done_cnt - d0), 1);

    // T2: 20 beats against a stalled DMA fills all 16 entries
    expect_run(20, 101);
    m_tready = 1'b0;
    accepted = 0;
    d0       = done_cnt;
    do_start(20);
    fork
      send_beats(20, 101);
      begin
        repeat (25) @(posedge aclk);
        #1;
        check("t2_accepted_full", DW'(accepted), 16);
        check("t2_s_tready_full", DW'(s_tready), 0);
        check("t2_m_tvalid", DW'(m_tvalid), 1);
        check("t2_head_data", m_tdata, 101);
        m_tready = 1'b1;
        wait_done(100);
      end
    join
    @(posedge aclk);
    #1;
    check("t2_accepted_all", DW'(accepted), 20);
    check("t2_queue_empty", DW'(exp_q.size()), 0);
    check("t2_done_count", DW'(done_cnt - d0), 1);

    // T3: upstream offers more beats than xfer_len
    expect_run(3, 11);
    m_tready = 1'b1;
    accepted = 0;
    d0       = done_cnt;
    do_start(3);
    send_beats(3, 11);
    s_tvalid = 1'b1;
    s_tdata  = DW'(14);
    check("t3_s_tready_after_len", DW'(s_tready), 0);
    wait_done(20);
    repeat (3) begin
      @(negedge aclk);
      check("t3_s_tready_held", DW'(s_tready), 0);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    check("t3_accepted", DW'(accepted), 3);
    check("t3_queue_empty", DW'(exp_q.size()), 0);
    check("t3_done_count", DW'(done_cnt - d0), 1);

    // T4a: zero-length transfer
    d0 = done_cnt;
    do_start(0);
    @(negedge aclk);
    check("t4_zero_done", DW'(done), 1);
    check("t4_zero_busy", DW'(busy), 1);
    check("t4_zero_m_tvalid", DW'(m_tvalid), 0);
    @(negedge aclk);
    check("t4_zero_done_pulse", DW'(done), 0);
    check("t4_zero_busy_idle", DW'(busy), 0);
    check("t4_zero_m_tvalid2", DW'(m_tvalid), 0);
    @(posedge aclk);
    #1;
    check("t4_zero_done_count", DW'(done_cnt - d0), 1);

    // T4b: start while busy must not retarget the length
    expect_run(2, 201);
    m_tready = 1'b1;
    d0       = done_cnt;
    do_start(2);
    fork
      send_beats(2, 201);
      begin
        start    = 1'b1;
        xfer_len = 32'd5;
        @(posedge aclk);
        #1;
        start = 1'b0;
        check("t4_busy_mid_run", DW'(busy), 1);
      end
    join
    wait_done(20);
    @(posedge aclk);
    #1;
    check("t4_s_tready_idle", DW'(s_tready), 0);
    check("t4_queue_empty", DW'(exp_q.size()), 0);
    check("t4_done_count", DW'(done_cnt - d0), 1);

    // T5: asynchronous reset with 5 beats buffered
    m_tready = 1'b0;
    do_start(8);
    send_beats(5, 31);
    repeat (2) @(posedge aclk);
    #1;
    check("t5_pre_valid", DW'(m_tvalid), 1);
    check("t5_pre_busy", DW'(busy), 1);
    #2;
    areset_n = 1'b0;
    #1;
    check("t5_async_m_tvalid", DW'(m_tvalid), 0);
    check("t5_async_s_tready", DW'(s_tready), 0);
    check("t5_async_busy", DW'(busy), 0);
    check("t5_async_m_tdata", m_tdata, 0);
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    expect_run(2, 41);
    m_tready = 1'b1;
    d0       = done_cnt;
    do_start(2);
    send_beats(2, 41);
    wait_done(20);
    @(posedge aclk);
    #1;
    check("t5_queue_empty", DW'(exp_q.size()), 0);
    check("t5_done_count", DW'(done_cnt - d0), 1);

`ifdef TY_OSTALL_CNT_EN
    // T6: seven stalled cycles are counted, then cleared by the next start
    expect_run(8, 51);
    m_tready = 1'b0;
    do_start(8);
    fork
      send_beats(8, 51);
      begin
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
          @(negedge aclk);
          if (m_tvalid) seen = 1'b1;
        end
        check("t6_valid_seen", DW'(seen), 1);
        repeat (6) @(negedge aclk);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        wait_done(40);
        check("t6_stall_at_done", DW'(stall_cnt), 7);
      end
    join
    @(posedge aclk);
    #1;
    check("t6_stall_held", DW'(stall_cnt), 7);
    do_start(0);
    check("t6_stall_cleared", DW'(stall_cnt), 0);
    repeat (2) @(posedge aclk);
    #1;
    check("t6_queue_empty", DW'(exp_q.size()), 0);
`endif

    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
